// File: rtl/fu_complete_buffer_pkg.sv
// Shared sizing and types for the FU completion buffer and its rotating selector.
package fu_complete_buffer_pkg;

  localparam int NUM_FU          = 5;
  localparam int SUPERSCALAR_WAY = 2;
  localparam int PHY_REG_NUM     = 8;
  localparam int PREG_W          = $clog2(PHY_REG_NUM);
  localparam int PTR_W           = $clog2(NUM_FU);

  typedef logic [PREG_W-1:0] preg_idx_t;
  typedef logic [NUM_FU-1:0] fu_vec_t;
  typedef logic [PTR_W-1:0]  ptr_t;

  // Advance a slot index by one, wrapping NUM_FU-1 back to 0.
  function automatic ptr_t ptr_inc(input int idx);
    return (idx >= NUM_FU - 1) ? '0 : ptr_t'(idx + 1);
  endfunction

endpackage

// File: rtl/fu_complete_buffer_rr_multi_select.sv
// Rotating-priority selector: grants up to SUPERSCALAR_WAY requests starting at start_ptr.
// Purely combinational; next_ptr points one past the last granted slot.
module fu_complete_buffer_rr_multi_select
  import fu_complete_buffer_pkg::*;
(
  input  logic [NUM_FU-1:0] req,
  input  logic [PTR_W-1:0]  start_ptr,
  output logic [NUM_FU-1:0] grant,
  output logic [PTR_W-1:0]  next_ptr
);

  int n_granted;

  always_comb begin
    grant     = '0;
    next_ptr  = start_ptr;
    n_granted = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      int   slot;
      ptr_t slot_p;
      slot = int'(start_ptr) + k;
      if (slot >= NUM_FU) slot = slot - NUM_FU;
      slot_p = ptr_t'(slot);
      if (req[slot_p] && (n_granted < SUPERSCALAR_WAY)) begin
        grant[slot_p] = 1'b1;
        n_granted     = n_granted + 1;
        next_ptr      = ptr_inc(slot);
      end
    end
  end

endmodule

// File: rtl/fu_complete_buffer.sv
// One-entry-per-FU completion buffer feeding the CDB with rotating-priority selection.
// Build option FU_COMPLETE_BYPASS_EN: empty slots with an incoming result may be forwarded same cycle.
module fu_complete_buffer
  import fu_complete_buffer_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_FU-1:0]              fu_valid_i,
  input  logic [NUM_FU-1:0][PREG_W-1:0]  fu_preg_i,
  output logic [NUM_FU-1:0]              fu_ready_o,
  input  logic                           squash_i,
  output logic [NUM_FU-1:0]              FU_complete_o,
  output logic [NUM_FU-1:0][PREG_W-1:0]  ready_reg_index_o
);

  fu_vec_t   vld;
  preg_idx_t preg [NUM_FU];
  ptr_t      rr_ptr;

  fu_vec_t   req;
  fu_vec_t   grant_raw;
  fu_vec_t   grant;
  fu_vec_t   xfer;
  fu_vec_t   store;
  ptr_t      next_ptr;
  preg_idx_t cand_preg [NUM_FU];

  always_comb begin
`ifdef FU_COMPLETE_BYPASS_EN
    req = vld | (fu_valid_i & {NUM_FU{~squash_i}});
    for (int i = 0; i < NUM_FU; i++) begin
      cand_preg[i] = vld[i] ? preg[i] : fu_preg_i[i];
    end
`else
    req = vld;
    for (int i = 0; i < NUM_FU; i++) begin
      cand_preg[i] = preg[i];
    end
`endif
  end

  fu_complete_buffer_rr_multi_select u_select (
    .req       (req),
    .start_ptr (rr_ptr),
    .grant     (grant_raw),
    .next_ptr  (next_ptr)
  );

  // Squash suppresses every grant and every transfer for the cycle.
  always_comb begin
    grant      = squash_i ? '0 : grant_raw;
    fu_ready_o = squash_i ? '0 : (~vld | grant);
    xfer       = fu_valid_i & fu_ready_o;
    store      = xfer & ~(grant & ~vld);
    FU_complete_o = grant;
    for (int i = 0; i < NUM_FU; i++) begin
      ready_reg_index_o[i] = grant[i] ? cand_preg[i] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld    <= '0;
      rr_ptr <= '0;
      for (int i = 0; i < NUM_FU; i++) preg[i] <= '0;
    end else begin
      if (squash_i) begin
        vld <= '0;
      end else begin
        for (int i = 0; i < NUM_FU; i++) begin
          if (store[i]) begin
            vld[i]  <= 1'b1;
            preg[i] <= fu_preg_i[i];
          end else if (grant[i]) begin
            vld[i]  <= 1'b0;
          end
        end
      end
      if (|grant) rr_ptr <= next_ptr;
    end
  end

endmodule

// File: tb/tb_fu_complete_buffer.sv
// Self-checking bench for fu_complete_buffer: directed scenarios plus a randomized scoreboard run.
module tb_fu_complete_buffer;
  import fu_complete_buffer_pkg::*;

  typedef logic [NUM_FU-1:0][PREG_W-1:0] preg_vec_t;
  localparam int STARVE = (NUM_FU + SUPERSCALAR_WAY - 1) / SUPERSCALAR_WAY;

  logic      clk = 1'b0;
  logic      reset;
  fu_vec_t   fu_valid_i;
  preg_vec_t fu_preg_i;
  fu_vec_t   fu_ready_o;
  logic      squash_i;
  fu_vec_t   FU_complete_o;
  preg_vec_t ready_reg_index_o;

  int checks   = 0;
  int failures = 0;

  preg_idx_t sb [NUM_FU][$];
  int        age [NUM_FU];

  always #5 clk = ~clk;

  fu_complete_buffer dut (
    .clk               (clk),
    .reset             (reset),
    .fu_valid_i        (fu_valid_i),
    .fu_preg_i         (fu_preg_i),
    .fu_ready_o        (fu_ready_o),
    .squash_i          (squash_i),
    .FU_complete_o     (FU_complete_o),
    .ready_reg_index_o (ready_reg_index_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    fu_valid_i = '0;
    fu_preg_i  = '0;
    squash_i   = 1'b0;
    reset      = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    fu_valid_i = '0; fu_preg_i = '0; squash_i = 1'b0;
    reset = 1'b0;
    #2;
    checks++;
    if (FU_complete_o !== 5'b00000) begin failures++; $display("FAIL reset_complete got=%b exp=00000", FU_complete_o); end
    do_reset();
    checks++;
    if (FU_complete_o !== 5'b00000) begin failures++; $display("FAIL idle_complete got=%b exp=00000", FU_complete_o); end
    checks++;
    if (fu_ready_o !== 5'b11111) begin failures++; $display("FAIL idle_ready got=%b exp=11111", fu_ready_o); end
    checks++;
    if (ready_reg_index_o !== '0) begin failures++; $display("FAIL idle_index got=%h exp=0", ready_reg_index_o); end
  endtask

  task automatic test_single();
    preg_vec_t e;
    do_reset();
    fu_valid_i = 5'b00001; fu_preg_i = '0; fu_preg_i[0] = 3'b010;
    #1;
    checks++;
    if (FU_complete_o !== 5'b00000) begin failures++; $display("FAIL single_lat0 got=%b exp=00000", FU_complete_o); end
    tick();
    fu_valid_i = '0;
    #1;
    e = '0; e[0] = 3'b010;
    checks++;
    if (FU_complete_o !== 5'b00001) begin failures++; $display("FAIL single_lat1 got=%b exp=00001", FU_complete_o); end
    checks++;
    if (ready_reg_index_o !== e) begin failures++; $display("FAIL single_index got=%h exp=%h", ready_reg_index_o, e); end
    tick();
    checks++;
    if (FU_complete_o !== 5'b00000) begin failures++; $display("FAIL single_drain got=%b exp=00000", FU_complete_o); end
  endtask

  task automatic test_multi();
    preg_vec_t e;
    do_reset();
    fu_valid_i = 5'b00111; fu_preg_i = '0;
    fu_preg_i[0] = 3'd5; fu_preg_i[1] = 3'd1; fu_preg_i[2] = 3'd3;
    tick();
    fu_valid_i = '0;
    #1;
    e = '0; e[0] = 3'd5; e[1] = 3'd1;
    checks++;
    if (FU_complete_o !== 5'b00011) begin failures++; $display("FAIL multi_g1 got=%b exp=00011", FU_complete_o); end
    checks++;
    if (ready_reg_index_o !== e) begin failures++; $display("FAIL multi_idx1 got=%h exp=%h", ready_reg_index_o, e); end
    checks++;
    if (fu_ready_o !== 5'b11011) begin failures++; $display("FAIL multi_ready got=%b exp=11011", fu_ready_o); end
    tick();
    e = '0; e[2] = 3'd3;
    checks++;
    if (FU_complete_o !== 5'b00100) begin failures++; $display("FAIL multi_g2 got=%b exp=00100", FU_complete_o); end
    checks++;
    if (ready_reg_index_o !== e) begin failures++; $display("FAIL multi_idx2 got=%h exp=%h", ready_reg_index_o, e); end
    // rr_ptr should now be 3: load slots 0,1,4 and expect 4 then 0 first.
    fu_valid_i = 5'b10011; fu_preg_i = '0;
    fu_preg_i[0] = 3'd6; fu_preg_i[1] = 3'd7; fu_preg_i[4] = 3'd4;
    tick();
    fu_valid_i = '0;
    #1;
    e = '0; e[0] = 3'd6; e[4] = 3'd4;
    checks++;
    if (FU_complete_o !== 5'b10001) begin failures++; $display("FAIL rrptr3_grant got=%b exp=10001", FU_complete_o); end
    checks++;
    if (ready_reg_index_o !== e) begin failures++; $display("FAIL rrptr3_idx got=%h exp=%h", ready_reg_index_o, e); end
    checks++;
    if (fu_ready_o !== 5'b11101) begin failures++; $display("FAIL rrptr3_ready got=%b exp=11101", fu_ready_o); end
    tick();
    e = '0; e[1] = 3'd7;
    checks++;
    if (FU_complete_o !== 5'b00010 || ready_reg_index_o !== e) begin
      failures++; $display("FAIL rrptr3_tail got=%b/%h exp=00010/%h", FU_complete_o, ready_reg_index_o, e);
    end
  endtask

  task automatic test_wrap_full();
    preg_vec_t e;
    do_reset();
    fu_valid_i = 5'b01000; fu_preg_i = '0; fu_preg_i[3] = 3'd2;
    tick();
    fu_valid_i = '0;
    #1;
    checks++;
    if (FU_complete_o !== 5'b01000) begin failures++; $display("FAIL wrap_setup got=%b exp=01000", FU_complete_o); end
    tick();
    fu_valid_i = 5'b11111;
    for (int i = 0; i < NUM_FU; i++) fu_preg_i[i] = preg_idx_t'(i + 1);
    #1;
    checks++;
    if (fu_ready_o !== 5'b11111) begin failures++; $display("FAIL wrap_fill_ready got=%b exp=11111", fu_ready_o); end
    tick();
    // Stalled FUs 1..3 present new indices that must not be accepted.
    fu_valid_i = 5'b01110; fu_preg_i = '0;
    fu_preg_i[1] = 3'd7; fu_preg_i[2] = 3'd7; fu_preg_i[3] = 3'd7;
    #1;
    e = '0; e[0] = 3'd1; e[4] = 3'd5;
    checks++;
    if (FU_complete_o !== 5'b10001) begin failures++; $display("FAIL full_wrap_grant got=%b exp=10001", FU_complete_o); end
    checks++;
    if (ready_reg_index_o !== e) begin failures++; $display("FAIL full_wrap_idx got=%h exp=%h", ready_reg_index_o, e); end
    checks++;
    if (fu_ready_o !== 5'b10001) begin failures++; $display("FAIL full_backpressure got=%b exp=10001", fu_ready_o); end
    tick();
    fu_valid_i = '0;
    #1;
    e = '0; e[1] = 3'd2; e[2] = 3'd3;
    checks++;
    if (FU_complete_o !== 5'b00110 || ready_reg_index_o !== e) begin
      failures++; $display("FAIL full_next got=%b/%h exp=00110/%h", FU_complete_o, ready_reg_index_o, e);
    end
    tick();
    e = '0; e[3] = 3'd4;
    checks++;
    if (FU_complete_o !== 5'b01000 || ready_reg_index_o !== e) begin
      failures++; $display("FAIL full_last got=%b/%h exp=01000/%h", FU_complete_o, ready_reg_index_o, e);
    end
    tick();
    checks++;
    if (FU_complete_o !== 5'b00000) begin failures++; $display("FAIL full_empty got=%b exp=00000", FU_complete_o); end
  endtask

  task automatic test_back_to_back();
    preg_vec_t e;
    do_reset();
    fu_valid_i = 5'b00001; fu_preg_i = '0; fu_preg_i[0] = 3'd1;
    tick();
    fu_preg_i[0] = 3'd7;
    #1;
    e = '0; e[0] = 3'd1;
    checks++;
    if (FU_complete_o !== 5'b00001 || ready_reg_index_o !== e || fu_ready_o[0] !== 1'b1) begin
      failures++; $display("FAIL b2b_first got=%b/%h/%b exp=00001/%h/1", FU_complete_o, ready_reg_index_o, fu_ready_o[0], e);
    end
    tick();
    fu_valid_i = '0;
    #1;
    e = '0; e[0] = 3'd7;
    checks++;
    if (FU_complete_o !== 5'b00001 || ready_reg_index_o !== e) begin
      failures++; $display("FAIL b2b_refill got=%b/%h exp=00001/%h", FU_complete_o, ready_reg_index_o, e);
    end
    tick();
    checks++;
    if (FU_complete_o !== 5'b00000) begin failures++; $display("FAIL b2b_drain got=%b exp=00000", FU_complete_o); end
  endtask

  task automatic test_squash();
    do_reset();
    fu_valid_i = 5'b00011; fu_preg_i = '0; fu_preg_i[0] = 3'd1; fu_preg_i[1] = 3'd2;
    tick();
    squash_i = 1'b1; fu_valid_i = 5'b00100; fu_preg_i = '0; fu_preg_i[2] = 3'd5;
    #1;
    checks++;
    if (FU_complete_o !== 5'b00000) begin failures++; $display("FAIL squash_complete got=%b exp=00000", FU_complete_o); end
    checks++;
    if (fu_ready_o !== 5'b00000) begin failures++; $display("FAIL squash_ready got=%b exp=00000", fu_ready_o); end
    tick();
    squash_i = 1'b0; fu_valid_i = '0;
    #1;
    checks++;
    if (FU_complete_o !== 5'b00000 || fu_ready_o !== 5'b11111) begin
      failures++; $display("FAIL squash_after got=%b/%b exp=00000/11111", FU_complete_o, fu_ready_o);
    end
    tick();
    checks++;
    if (FU_complete_o !== 5'b00000) begin failures++; $display("FAIL squash_ignored_valid got=%b exp=00000", FU_complete_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fu_valid_i = 5'b11111;
    for (int i = 0; i < NUM_FU; i++) fu_preg_i[i] = preg_idx_t'(i + 2);
    tick();
    fu_valid_i = '0;
    #1;
    checks++;
    if (FU_complete_o !== 5'b00011) begin failures++; $display("FAIL mid_pre got=%b exp=00011", FU_complete_o); end
    reset = 1'b0;
    #1;
    checks++;
    if (FU_complete_o !== 5'b00000 || fu_ready_o !== 5'b11111 || ready_reg_index_o !== '0) begin
      failures++; $display("FAIL mid_reset got=%b/%b/%h exp=00000/11111/0", FU_complete_o, fu_ready_o, ready_reg_index_o);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (FU_complete_o !== 5'b00000) begin failures++; $display("FAIL mid_after got=%b exp=00000", FU_complete_o); end
  endtask

`ifdef FU_COMPLETE_BYPASS_EN
  task automatic test_bypass();
    preg_vec_t e;
    do_reset();
    fu_valid_i = 5'b00001; fu_preg_i = '0; fu_preg_i[0] = 3'd6;
    #1;
    e = '0; e[0] = 3'd6;
    checks++;
    if (FU_complete_o !== 5'b00001 || ready_reg_index_o !== e) begin
      failures++; $display("FAIL bypass_same got=%b/%h exp=00001/%h", FU_complete_o, ready_reg_index_o, e);
    end
    tick();
    fu_valid_i = '0;
    #1;
    checks++;
    if (FU_complete_o !== 5'b00000) begin failures++; $display("FAIL bypass_next got=%b exp=00000", FU_complete_o); end
  endtask
`else
  task automatic test_random();
    fu_vec_t   occ;
    fu_vec_t   exp_ready;
    preg_idx_t exp_p;
    int        n_occ;
    int        exp_cnt;
    int        ncyc;
    do_reset();
    for (int i = 0; i < NUM_FU; i++) begin sb[i].delete(); age[i] = 0; end
    ncyc = 600;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (cyc < ncyc - 6) begin
        fu_valid_i = fu_vec_t'($urandom);
        fu_preg_i  = preg_vec_t'($urandom);
        squash_i   = ($urandom_range(0, 24) == 0);
      end else begin
        fu_valid_i = '0;
        squash_i   = 1'b0;
      end
      #1;
      occ = '0;
      for (int i = 0; i < NUM_FU; i++) occ[i] = (sb[i].size() != 0);
      n_occ = $countones(occ);
      if (squash_i) begin
        checks++;
        if (FU_complete_o !== '0 || fu_ready_o !== '0) begin
          failures++; $display("FAIL rnd_squash cyc=%0d got=%b/%b exp=00000/00000", cyc, FU_complete_o, fu_ready_o);
        end
        for (int i = 0; i < NUM_FU; i++) begin sb[i].delete(); age[i] = 0; end
      end else begin
        exp_cnt = (n_occ < SUPERSCALAR_WAY) ? n_occ : SUPERSCALAR_WAY;
        checks++;
        if ($countones(FU_complete_o) != exp_cnt || (FU_complete_o & ~occ) != '0) begin
          failures++; $display("FAIL rnd_grant cyc=%0d got=%b occ=%b exp_count=%0d", cyc, FU_complete_o, occ, exp_cnt);
        end
        exp_ready = ~occ | (FU_complete_o & occ);
        checks++;
        if (fu_ready_o !== exp_ready) begin
          failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, fu_ready_o, exp_ready);
        end
        for (int i = 0; i < NUM_FU; i++) begin
          if (occ[i]) begin
            if (FU_complete_o[i]) begin
              exp_p = sb[i].pop_front();
              age[i] = 0;
              checks++;
              if (ready_reg_index_o[i] !== exp_p) begin
                failures++; $display("FAIL rnd_index cyc=%0d fu=%0d got=%0d exp=%0d", cyc, i, ready_reg_index_o[i], exp_p);
              end
            end else begin
              age[i]++;
              checks++;
              if (age[i] >= STARVE) begin
                failures++; $display("FAIL rnd_starve cyc=%0d fu=%0d got_wait=%0d exp_max=%0d", cyc, i, age[i], STARVE - 1);
              end
            end
          end
          if (fu_valid_i[i] && exp_ready[i]) begin
            sb[i].push_back(fu_preg_i[i]);
            age[i] = 0;
          end
        end
      end
      tick();
    end
    n_occ = 0;
    for (int i = 0; i < NUM_FU; i++) n_occ += sb[i].size();
    checks++;
    if (n_occ != 0 || FU_complete_o !== '0) begin
      failures++; $display("FAIL rnd_drain got_pending=%0d complete=%b exp=0/00000", n_occ, FU_complete_o);
    end
  endtask
`endif

  initial begin
    reset = 1'b0;
    fu_valid_i = '0;
    fu_preg_i  = '0;
    squash_i   = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_wrap_full();
    test_back_to_back();
    test_squash();
    test_reset_mid();
`ifdef FU_COMPLETE_BYPASS_EN
    test_bypass();
`else
    test_random();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
